mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access pipeline stage directly downstream of the ALU in the RV32I core. It consumes the ALU result as an effective address (or as pass-through writeback data), performs byte/half/word loads and stores against the data memory over a request/acknowledge handshake, and presents aligned, extended writeback data to the WB stage. It also stalls the upstream stage while an access is outstanding.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5.
- clk  in  1  single clock; all registers update on the rising edge
- rstn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage presents an instruction
- ex_ready  out  1  stage can accept; equals (state == IDLE)
- ex_mem_read  in  1  load instruction
- ex_mem_write  in  1  store instruction
- ex_funct3  in  3  RV32I load/store width field
- ex_alu_result  in  32  effective address for load/store; writeback data otherwise
- ex_rs2_data  in  32  store data
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = store
- dm_addr  out  32  word address, {addr[31:2], 2'b00}
- dm_be  out  4  byte enables; bit i selects byte i (little-endian)
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  memory accepts; for loads, dm_rdata is valid in the same cycle
- dm_rdata  in  32  load data word
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write  out  1  qualified write enable to the register file
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- mem_err  out  1  one-cycle pulse, coincident with wb_valid, for a faulting access

## Operation
- FSM states: IDLE and BUSY. The FSM resets to IDLE.
- IDLE, ex_valid=1, and no memory op: register ex_alu_result, ex_rd, and ex_reg_write into the wb outputs. Next cycle wb_valid=1. State stays IDLE.
- IDLE, ex_valid=1, and a legal memory op: latch the address, funct3, store data, rd, reg_write, and we. Next state is BUSY.
- BUSY: dm_req=1, with dm_we, dm_addr, dm_be, and dm_wdata driven from the latched values. All of them stay stable until dm_ack.
- BUSY with dm_ack=1, load:
  - Capture the extended load value into wb_data, wb_valid=1 next cycle, wb_reg_write equals the latched reg_write.
  - Return to IDLE.
- BUSY with dm_ack=1, store: wb_valid=1 next cycle, wb_reg_write=0. Return to IDLE.
- Faulting op: no memory request, wb_valid=1 and mem_err=1 next cycle, wb_reg_write=0. State stays IDLE. A faulting op is any of:
  - LH, LHU, or SH with addr[0]=1
  - LW or SW with addr[1:0]≠0
  - load funct3 ∈ {011, 110, 111}
  - store funct3 ≥ 011
  - ex_mem_read and ex_mem_write both 1
- Byte enables and store data:
  - SB: be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}
  - SW: be = 1111, wdata = rs2
- Loads:
  - LB and LBU: lane = rdata byte addr[1:0].
  - LH and LHU: lane = halfword addr[1].
  - LB and LH sign-extend. LBU and LHU zero-extend.
  - For loads, dm_be follows the same rules as stores.
- Upstream holds its ex_* inputs stable while ex_valid=1 and ex_ready=0.
- Whenever wb_valid=0, wb_reg_write=0.

## Timing
- Reset: state=IDLE and ex_ready=1. dm_req, dm_we, dm_addr, dm_be, dm_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, and mem_err are all 0.
- Asserting rstn=0 mid-access drops dm_req asynchronously. The pending access is abandoned and no wb_valid is produced.
- Non-memory op: 1-cycle latency, accepted at edge N, wb_valid during cycle N+1. Throughput is 1 per cycle.
- Memory op, accepted at edge N:
  - dm_req rises in cycle N+1.
  - With dm_ack in cycle N+1+k, wb_valid occurs in cycle N+2+k and ex_ready returns to 1 in the same cycle.
  - Minimum latency is 2 cycles, and a new instruction can be accepted in that same cycle.
- dm_req deasserts in the cycle after dm_ack. It is never asserted for two consecutive accesses without an intervening IDLE cycle.
- dm_ack while not BUSY is ignored.
- ex_ready is combinational from state only. It never depends on ex_valid or dm_ack.

## Test plan
- Reset: hold rstn=0 and check every output is 0 and ex_ready=1. Release rstn, drive an ADD result 0x0000_1234 with rd=5 and reg_write=1. Next cycle: wb_valid=1, wb_rd=5, wb_data=0x1234.
- SB, addr=0x103, rs2=0x0000_00A5, dm_ack on the first request cycle → dm_addr=0x100, dm_be=1000, dm_wdata=0xA5A5_A5A5, dm_we=1. Then wb_valid=1 with wb_reg_write=0, and 2-cycle latency.
- LB / LBU / LH / LHU with rdata=0x80FF_7F01:
  - LB at 0x2 → 0x0000_00FF sign-extended = 0xFFFF_FFFF.
  - LBU at 0x3 → 0x0000_0080.
  - LH at 0x2 → 0xFFFF_80FF.
  - LHU at 0x0 → 0x0000_7F01.
- LW at 0x40 with dm_ack held low for 3 cycles → dm_req stays 1 for 4 cycles with constant addr and be=1111, and ex_ready=0 throughout. wb_valid occurs the cycle after dm_ack.
- Misaligned LW at 0x42, then SH at 0x101 → no dm_req. Each produces wb_valid=1, mem_err=1, wb_reg_write=0 one cycle after acceptance.
- rstn pulsed low during BUSY with dm_ack=0 → dm_req drops immediately, no wb_valid, ex_ready=1 after release.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access stage between EX and WB.
// Ports: ex_* from EX (valid/ready), dm_* data-memory req/ack bus,
//   wb_* registered writeback to WB, mem_err fault pulse with wb_valid.
module mem_access_stage (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [3:0]  dm_be_q, dm_be_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [1:0]  lo_q, lo_d;
   logic [2:0]  f3_q, f3_d;
   logic        rw_q, rw_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        mem_err_q, mem_err_d;

   logic [1:0]  a;
   logic        ld_bad, st_bad, fault, mem_op;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] shifted;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] ld_val;

   assign a      = ex_alu_result[1:0];
   assign mem_op = ex_mem_read | ex_mem_write;

   always_comb begin
      ld_bad = 1'b1;
      st_bad = 1'b1;
      case (ex_funct3)
         3'b000, 3'b100: ld_bad = 1'b0;
         3'b001, 3'b101: ld_bad = a[0];
         3'b010:         ld_bad = (a != 2'b00);
         default:        ld_bad = 1'b1;
      endcase
      case (ex_funct3)
         3'b000:  st_bad = 1'b0;
         3'b001:  st_bad = a[0];
         3'b010:  st_bad = (a != 2'b00);
         default: st_bad = 1'b1;
      endcase
      fault = (ex_mem_read & ex_mem_write)
            | (ex_mem_read & ld_bad)
            | (ex_mem_write & st_bad);
   end

   // Lane selection shared by loads and stores; funct3[2] only picks
   // the load extension, so decode on the width bits alone.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = ex_rs2_data;
      case (ex_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << a;
            wdata_c = {4{ex_rs2_data[7:0]}};
         end
         2'b01: begin
            be_c    = a[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{ex_rs2_data[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = ex_rs2_data;
         end
      endcase
   end

   always_comb begin
      shifted = dm_rdata >> {lo_q, 3'b000};
      lb      = shifted[7:0];
      lh      = lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (f3_q)
         3'b000:  ld_val = {{24{lb[7]}}, lb};
         3'b100:  ld_val = {24'h0, lb};
         3'b001:  ld_val = {{16{lh[15]}}, lh};
         3'b101:  ld_val = {16'h0, lh};
         default: ld_val = dm_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      dm_req_d       = dm_req_q;
      dm_we_d        = dm_we_q;
      dm_addr_d      = dm_addr_q;
      dm_be_d        = dm_be_q;
      dm_wdata_d     = dm_wdata_q;
      lo_d           = lo_q;
      f3_d           = f3_q;
      rw_d           = rw_q;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      mem_err_d      = 1'b0;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      unique case (state_q)
         IDLE: begin
            if (ex_valid) begin
               wb_rd_d = ex_rd;
               if (!mem_op) begin
                  wb_valid_d     = 1'b1;
                  wb_reg_write_d = ex_reg_write;
                  wb_data_d      = ex_alu_result;
               end else if (fault) begin
                  wb_valid_d = 1'b1;
                  mem_err_d  = 1'b1;
               end else begin
                  state_d    = BUSY;
                  dm_req_d   = 1'b1;
                  dm_we_d    = ex_mem_write;
                  dm_addr_d  = {ex_alu_result[31:2], 2'b00};
                  dm_be_d    = be_c;
                  dm_wdata_d = wdata_c;
                  lo_d       = a;
                  f3_d       = ex_funct3;
                  rw_d       = ex_reg_write;
               end
            end
         end
         BUSY: begin
            if (dm_ack) begin
               state_d    = IDLE;
               dm_req_d   = 1'b0;
               wb_valid_d = 1'b1;
               if (!dm_we_q) begin
                  wb_data_d      = ld_val;
                  wb_reg_write_d = rw_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         dm_req_q       <= 1'b0;
         dm_we_q        <= 1'b0;
         dm_addr_q      <= 32'h0;
         dm_be_q        <= 4'h0;
         dm_wdata_q     <= 32'h0;
         lo_q           <= 2'b00;
         f3_q           <= 3'b000;
         rw_q           <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= 32'h0;
         mem_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         dm_req_q       <= dm_req_d;
         dm_we_q        <= dm_we_d;
         dm_addr_q      <= dm_addr_d;
         dm_be_q        <= dm_be_d;
         dm_wdata_q     <= dm_wdata_d;
         lo_q           <= lo_d;
         f3_q           <= f3_d;
         rw_q           <= rw_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         mem_err_q      <= mem_err_d;
      end
   end

   assign ex_ready     = (state_q == IDLE);
   assign dm_req       = dm_req_q;
   assign dm_we        = dm_we_q;
   assign dm_addr      = dm_addr_q;
   assign dm_be        = dm_be_q;
   assign dm_wdata     = dm_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed-vector bench for mem_access_stage.
// Drives EX and data-memory sides, checks dm_* and wb_* against constants.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ex_valid, ex_ready;
   logic        ex_mem_read, ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result, ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rstn(rstn),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
      .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rdi,
                        input logic rw);
      ex_valid      = 1'b1;
      ex_mem_read   = rd;
      ex_mem_write  = wr;
      ex_funct3     = f3;
      ex_alu_result = addr;
      ex_rs2_data   = rs2;
      ex_rd         = rdi;
      ex_reg_write  = rw;
   endtask

   task automatic idle_in();
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr,
                          input logic [3:0] exp_be,
                          input logic [31:0] exp);
      issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 1'b1);
      tick();
      idle_in();
      chk({tag, "_req"}, {31'h0, dm_req}, 32'h1);
      chk({tag, "_we"}, {31'h0, dm_we}, 32'h0);
      chk({tag, "_be"}, {28'h0, dm_be}, {28'h0, exp_be});
      dm_ack   = 1'b1;
      dm_rdata = 32'h80FF_7F01;
      tick();
      dm_ack = 1'b0;
      chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'h1);
      chk({tag, "_wbrw"}, {31'h0, wb_reg_write}, 32'h1);
      chk({tag, "_rd"}, {27'h0, wb_rd}, 32'd9);
      chk({tag, "_data"}, wb_data, exp);
   endtask

   initial begin
      rstn     = 1'b0;
      dm_ack   = 1'b0;
      dm_rdata = 32'h0;
      idle_in();
      ex_funct3     = 3'b000;
      ex_alu_result = 32'h0;
      ex_rs2_data   = 32'h0;
      ex_rd         = 5'd0;
      ex_reg_write  = 1'b0;
      tick();
      tick();
      chk("rst_ready", {31'h0, ex_ready}, 32'h1);
      chk("rst_req", {31'h0, dm_req}, 32'h0);
      chk("rst_we", {31'h0, dm_we}, 32'h0);
      chk("rst_addr", dm_addr, 32'h0);
      chk("rst_be", {28'h0, dm_be}, 32'h0);
      chk("rst_wdata", dm_wdata, 32'h0);
      chk("rst_wbv", {31'h0, wb_valid}, 32'h0);
      chk("rst_wbrw", {31'h0, wb_reg_write}, 32'h0);
      chk("rst_wbrd", {27'h0, wb_rd}, 32'h0);
      chk("rst_wbdata", wb_data, 32'h0);
      chk("rst_err", {31'h0, mem_err}, 32'h0);
      rstn = 1'b1;
      tick();

      // ALU pass-through
      issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
      tick();
      idle_in();
      chk("add_wbv", {31'h0, wb_valid}, 32'h1);
      chk("add_rd", {27'h0, wb_rd}, 32'd5);
      chk("add_data", wb_data, 32'h0000_1234);
      chk("add_rw", {31'h0, wb_reg_write}, 32'h1);
      tick();
      chk("add_wbv_end", {31'h0, wb_valid}, 32'h0);
      chk("add_rw_end", {31'h0, wb_reg_write}, 32'h0);

      // SB with ack on first request cycle
      issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd3, 1'b0);
      tick();
      idle_in();
      chk("sb_req", {31'h0, dm_req}, 32'h1);
      chk("sb_we", {31'h0, dm_we}, 32'h1);
      chk("sb_addr", dm_addr, 32'h0000_0100);
      chk("sb_be", {28'h0, dm_be}, 32'h8);
      chk("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
      chk("sb_ready", {31'h0, ex_ready}, 32'h0);
      chk("sb_wbv0", {31'h0, wb_valid}, 32'h0);
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;
      chk("sb_wbv", {31'h0, wb_valid}, 32'h1);
      chk("sb_wbrw", {31'h0, wb_reg_write}, 32'h0);
      chk("sb_err", {31'h0, mem_err}, 32'h0);
      chk("sb_req_off", {31'h0, dm_req}, 32'h0);
      chk("sb_ready1", {31'h0, ex_ready}, 32'h1);

      // SH / SW lanes
      issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 5'd0, 1'b0);
      tick();
      idle_in();
      chk("sh_be", {28'h0, dm_be}, 32'hC);
      chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;
      issue(1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'hDEAD_0001, 5'd0, 1'b0);
      tick();
      idle_in();
      chk("sw_be", {28'h0, dm_be}, 32'hF);
      chk("sw_addr", dm_addr, 32'h0000_0304);
      chk("sw_wdata", dm_wdata, 32'hDEAD_0001);
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;

      // loads against rdata 0x80FF_7F01
      do_load("lb", 3'b000, 32'h0000_0002, 4'b0100, 32'hFFFF_FFFF);
      do_load("lbu", 3'b100, 32'h0000_0003, 4'b1000, 32'h0000_0080);
      do_load("lh", 3'b001, 32'h0000_0002, 4'b1100, 32'hFFFF_80FF);
      do_load("lhu", 3'b101, 32'h0000_0000, 4'b0011, 32'h0000_7F01);
      do_load("lb0", 3'b000, 32'h0000_0001, 4'b0010, 32'h0000_007F);

      // LW with three wait cycles
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd12, 1'b1);
      tick();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lw_req%0d", i), {31'h0, dm_req}, 32'h1);
         chk($sformatf("lw_addr%0d", i), dm_addr, 32'h0000_0040);
         chk($sformatf("lw_be%0d", i), {28'h0, dm_be}, 32'hF);
         chk($sformatf("lw_rdy%0d", i), {31'h0, ex_ready}, 32'h0);
         chk($sformatf("lw_wbv%0d", i), {31'h0, wb_valid}, 32'h0);
         if (i == 3) begin
            dm_ack   = 1'b1;
            dm_rdata = 32'h1357_9BDF;
         end
         tick();
      end
      dm_ack = 1'b0;
      chk("lw_wbv", {31'h0, wb_valid}, 32'h1);
      chk("lw_data", wb_data, 32'h1357_9BDF);
      chk("lw_rd", {27'h0, wb_rd}, 32'd12);
      chk("lw_rdy", {31'h0, ex_ready}, 32'h1);
      chk("lw_req_off", {31'h0, dm_req}, 32'h0);

      // back-to-back accept in the wb_valid cycle
      issue(1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 32'h0, 5'd7, 1'b1);
      tick();
      idle_in();
      chk("b2b_wbv", {31'h0, wb_valid}, 32'h1);
      chk("b2b_data", wb_data, 32'h0000_CAFE);
      chk("b2b_rd", {27'h0, wb_rd}, 32'd7);

      // stray ack in IDLE
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;
      chk("stray_wbv", {31'h0, wb_valid}, 32'h0);
      chk("stray_req", {31'h0, dm_req}, 32'h0);

      // faults: misaligned LW, misaligned SH, illegal load funct3
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0042, 32'h0, 5'd4, 1'b1);
      tick();
      chk("flw_req", {31'h0, dm_req}, 32'h0);
      chk("flw_wbv", {31'h0, wb_valid}, 32'h1);
      chk("flw_err", {31'h0, mem_err}, 32'h1);
      chk("flw_rw", {31'h0, wb_reg_write}, 32'h0);
      chk("flw_rdy", {31'h0, ex_ready}, 32'h1);
      issue(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 5'd0, 1'b0);
      tick();
      chk("fsh_req", {31'h0, dm_req}, 32'h0);
      chk("fsh_wbv", {31'h0, wb_valid}, 32'h1);
      chk("fsh_err", {31'h0, mem_err}, 32'h1);
      chk("fsh_rw", {31'h0, wb_reg_write}, 32'h0);
      issue(1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0, 5'd4, 1'b1);
      tick();
      chk("ff3_err", {31'h0, mem_err}, 32'h1);
      chk("ff3_req", {31'h0, dm_req}, 32'h0);
      issue(1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'h0, 5'd4, 1'b1);
      tick();
      idle_in();
      chk("frw_err", {31'h0, mem_err}, 32'h1);
      chk("frw_req", {31'h0, dm_req}, 32'h0);
      tick();
      chk("f_wbv_end", {31'h0, wb_valid}, 32'h0);
      chk("f_err_end", {31'h0, mem_err}, 32'h0);

      // reset during BUSY
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd6, 1'b1);
      tick();
      idle_in();
      chk("rb_req", {31'h0, dm_req}, 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      chk("rb_req_drop", {31'h0, dm_req}, 32'h0);
      chk("rb_rdy", {31'h0, ex_ready}, 32'h1);
      tick();
      rstn = 1'b1;
      tick();
      chk("rb_wbv", {31'h0, wb_valid}, 32'h0);
      chk("rb_rdy1", {31'h0, ex_ready}, 32'h1);
      chk("rb_req1", {31'h0, dm_req}, 32'h0);
      tick();
      chk("rb_wbv2", {31'h0, wb_valid}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
